// File: rtl/horner_poly_eval.sv
`default_nettype none
// ============================================================================
// horner_poly_eval: Horner-rule polynomial evaluator with one shared pipelined
// multiplier and adder and ready/valid on both sides. Macro: HORNER_OVF_EN. Rev 1.0
// ============================================================================
module horner_poly_eval #(
  parameter int WIDTH   = 64,
  parameter int DEGREE  = 4,
  parameter int MUL_LAT = 3,
  parameter int ADD_LAT = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            x,
  input  logic [(DEGREE+1)*WIDTH-1:0] coef,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            res,
  output logic                        busy,
  output logic                        ovf
);

  localparam int KW     = (DEGREE > 1) ? $clog2(DEGREE) : 1;
  localparam int MAXLAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
  localparam int CW     = $clog2(MAXLAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] c_q [DEGREE];
  logic [WIDTH-1:0] c_d [DEGREE];
  logic [WIDTH-1:0] mul_pipe_q [MUL_LAT];
  logic [WIDTH-1:0] mul_pipe_d [MUL_LAT];

  logic [WIDTH-1:0] mul_out;
  logic [WIDTH-1:0] add_in;
  logic [WIDTH-1:0] add_out;
  logic             accept;
  logic             add_last;
  logic             res_load;
  logic             out_hs;

  assign accept   = (state_q == IDLE) && in_valid;
  assign add_last = (state_q == ADD) && (cnt_q == CW'(ADD_LAT - 1));
  assign res_load = (state_q == DONE) && !out_valid_q;
  assign out_hs   = (state_q == DONE) && out_valid_q && out_ready;

  // Operands stay frozen for a whole phase, so a free-running pipe is full
  // with the correct product/sum by the time the phase counter expires.
  assign mul_out = mul_pipe_q[MUL_LAT-1];
  assign add_in  = mul_out + c_q[k_q];

  generate
    if (ADD_LAT > 1) begin : g_add_pipe
      logic [WIDTH-1:0] add_pipe_q [ADD_LAT-1];
      logic [WIDTH-1:0] add_pipe_d [ADD_LAT-1];

      always_comb begin
        add_pipe_d[0] = add_in;
        for (int i = 1; i < ADD_LAT - 1; i++) begin
          add_pipe_d[i] = add_pipe_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < ADD_LAT - 1; i++) begin
            add_pipe_q[i] <= '0;
          end
        end else begin
          add_pipe_q <= add_pipe_d;
        end
      end

      assign add_out = add_pipe_q[ADD_LAT-2];
    end else begin : g_add_direct
      // The accumulator register itself is the single adder stage.
      assign add_out = add_in;
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    x_d         = x_q;
    acc_d       = acc_q;
    res_d       = res_q;
    out_valid_d = out_valid_q;
    c_d         = c_q;

    mul_pipe_d[0] = acc_q * x_q;
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe_d[i] = mul_pipe_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (accept) begin
          x_d   = x;
          acc_d = coef[DEGREE*WIDTH +: WIDTH];
          for (int i = 0; i < DEGREE; i++) begin
            c_d[i] = coef[i*WIDTH +: WIDTH];
          end
          k_d     = KW'(DEGREE - 1);
          cnt_d   = '0;
          state_d = MUL;
        end
      end
      MUL: begin
        if (cnt_q == CW'(MUL_LAT - 1)) begin
          cnt_d   = '0;
          state_d = ADD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ADD: begin
        if (add_last) begin
          cnt_d = '0;
          acc_d = add_out;
          if (k_q == '0) begin
            state_d = DONE;
          end else begin
            k_d     = k_q - 1'b1;
            state_d = MUL;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (res_load) begin
          res_d       = acc_q;
          out_valid_d = 1'b1;
        end else if (out_hs) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < DEGREE; i++) begin
        c_q[i] <= '0;
      end
      for (int i = 0; i < MUL_LAT; i++) begin
        mul_pipe_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      mul_pipe_q  <= mul_pipe_d;
    end
  end

`ifdef HORNER_OVF_EN
  logic                   ovf_acc_q, ovf_acc_d;
  logic                   ovf_q, ovf_d;
  logic [2*WIDTH-1:0]     prod_full;
  logic                   mul_ovf;
  logic                   add_ovf;
  logic [WIDTH-1:0]       c_k;

  // Exact product of the frozen operands; overflow if it does not fit WIDTH bits signed.
  assign prod_full = {{WIDTH{acc_q[WIDTH-1]}}, acc_q} * {{WIDTH{x_q[WIDTH-1]}}, x_q};
  assign mul_ovf   = (prod_full != {{WIDTH{prod_full[WIDTH-1]}}, prod_full[WIDTH-1:0]});
  assign c_k       = c_q[k_q];
  assign add_ovf   = (mul_out[WIDTH-1] == c_k[WIDTH-1]) && (add_in[WIDTH-1] != mul_out[WIDTH-1]);

  always_comb begin
    ovf_acc_d = ovf_acc_q;
    ovf_d     = ovf_q;
    if (accept) begin
      ovf_acc_d = 1'b0;
    end else if (add_last) begin
      ovf_acc_d = ovf_acc_q | mul_ovf | add_ovf;
    end
    if (res_load) begin
      ovf_d = ovf_acc_q;
    end else if (out_hs) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      ovf_acc_q <= ovf_acc_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign res       = res_q;

endmodule
`default_nettype wire

// File: tb/tb_horner_poly_eval.sv
`default_nettype none
// ============================================================================
// tb_horner_poly_eval: randomized and directed bench for horner_poly_eval
// against a power-sum reference model. Rev 1.0
// ============================================================================
module tb_horner_poly_eval;

  localparam int W    = 64;
  localparam int D    = 4;
  localparam int ML   = 3;
  localparam int AL   = 2;
  localparam int CWID = (D + 1) * W;
  localparam int LAT  = D * (ML + AL) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    x;
  logic [CWID-1:0] coef;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    res;
  logic            busy;
  logic            ovf;

  logic            s_in_valid;
  logic            s_in_ready;
  logic [W-1:0]    s_x;
  logic [2*W-1:0]  s_coef;
  logic            s_out_valid;
  logic            s_out_ready;
  logic [W-1:0]    s_res;
  logic            s_busy;
  logic            s_ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  horner_poly_eval #(.WIDTH(W), .DEGREE(D), .MUL_LAT(ML), .ADD_LAT(AL)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .coef(coef), .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy), .ovf(ovf)
  );

  horner_poly_eval #(.WIDTH(W), .DEGREE(1), .MUL_LAT(1), .ADD_LAT(1)) u_small (
    .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .x(s_x), .coef(s_coef), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .res(s_res), .busy(s_busy), .ovf(s_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // y = sum c[k] * x^k modulo 2^W, evaluated directly as a power series.
  function automatic logic [W-1:0] model_res(input logic [W-1:0] xv, input logic [CWID-1:0] cv);
    logic [W-1:0] p;
    logic [W-1:0] s;
    p = 1;
    s = 0;
    for (int k = 0; k <= D; k++) begin
      s = s + cv[k*W +: W] * p;
      p = p * xv;
    end
    return s;
  endfunction

  function automatic logic model_ovf(input logic [W-1:0] xv, input logic [CWID-1:0] cv);
`ifdef HORNER_OVF_EN
    logic [W-1:0]   a;
    logic [W-1:0]   c;
    logic [W-1:0]   s;
    logic [2*W-1:0] full;
    logic           o;
    a = cv[D*W +: W];
    o = 1'b0;
    for (int k = D - 1; k >= 0; k--) begin
      full = {{W{a[W-1]}}, a} * {{W{xv[W-1]}}, xv};
      if (full != {{W{full[W-1]}}, full[W-1:0]}) o = 1'b1;
      c = cv[k*W +: W];
      s = full[W-1:0] + c;
      if ((full[W-1] == c[W-1]) && (s[W-1] != full[W-1])) o = 1'b1;
      a = s;
    end
    return o;
`else
    return (xv == '1) && (cv == '1) && 1'b0;
`endif
  endfunction

  logic [W-1:0] exp_res [$];
  logic         exp_ovf [$];
  int           exp_t   [$];
  int           accept_cnt  = 0;
  int           hs_cnt      = 0;
  int           last_accept = 0;
  int           hs_edge     = 0;
  int           gap_checks  = 0;
  bit           post_hs     = 0;
  bit           prev_ov     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_res.delete();
      exp_ovf.delete();
      exp_t.delete();
      post_hs = 0;
      prev_ov = 0;
      check("rst_out_valid", W'(out_valid), 0);
      check("rst_in_ready", W'(in_ready), 1);
      check("rst_busy", W'(busy), 0);
      check("rst_res", res, 0);
      check("rst_ovf", W'(ovf), 0);
    end else begin
      check("ready_vs_busy", W'(in_ready), W'(!busy));
      if (post_hs) begin
        check("in_ready_after_hs", W'(in_ready), 1);
        post_hs = 0;
      end
      if (in_valid && in_ready) begin
        last_accept = cyc + 1;
        if (gap_checks > 0) begin
          check("accept_gap", W'(last_accept), W'(hs_edge + 1));
          gap_checks--;
        end
        exp_res.push_back(model_res(x, coef));
        exp_ovf.push_back(model_ovf(x, coef));
        exp_t.push_back(last_accept);
        accept_cnt++;
      end
      if (out_valid) begin
        if (exp_res.size() == 0) begin
          fail("stale_result");
        end else begin
          check("res", res, exp_res[0]);
          check("ovf", W'(ovf), W'(exp_ovf[0]));
          check("in_ready_in_done", W'(in_ready), 0);
          if (!prev_ov) check("latency", W'(cyc - exp_t[0]), W'(LAT));
          if (out_ready) begin
            void'(exp_res.pop_front());
            void'(exp_ovf.pop_front());
            void'(exp_t.pop_front());
            hs_edge = cyc + 1;
            hs_cnt++;
            post_hs = 1;
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  function automatic logic [CWID-1:0] pack5(input logic [W-1:0] c4, input logic [W-1:0] c3,
                                            input logic [W-1:0] c2, input logic [W-1:0] c1,
                                            input logic [W-1:0] c0);
    return {c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [W-1:0] rnd64();
    logic [W-1:0] v;
    case ($urandom_range(0, 3))
      0:       v = W'($urandom_range(0, 7));
      1:       v = -W'($urandom_range(1, 9));
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  function automatic logic [CWID-1:0] rnd_coef();
    logic [CWID-1:0] v;
    for (int k = 0; k <= D; k++) v[k*W +: W] = rnd64();
    return v;
  endfunction

  // Presents an operand set at posedge+1 and returns just after the accept edge.
  task automatic do_accept(input logic [W-1:0] xv, input logic [CWID-1:0] cv);
    int old;
    int n;
    old      = accept_cnt;
    in_valid = 1'b1;
    x        = xv;
    coef     = cv;
    n        = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (accept_cnt == old && n < 500);
    if (accept_cnt == old) fail("accept_timeout");
  endtask

  task automatic scramble();
    x    = rnd64();
    coef = rnd_coef();
  endtask

  task automatic get_result(output logic [W-1:0] r, output int lat);
    int n;
    n = 0;
    while (!out_valid && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!out_valid) fail("result_timeout");
    r   = res;
    lat = cyc - last_accept;
  endtask

  task automatic wait_hs(input int target, input bit rnd_ready);
    int n;
    n = 0;
    while (hs_cnt < target && n < 2000) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (hs_cnt < target) fail("handshake_timeout");
  endtask

  task automatic directed(input string name, input logic [W-1:0] xv, input logic [CWID-1:0] cv,
                          input logic [W-1:0] want);
    logic [W-1:0] r;
    int           lat;
    int           tgt;
    tgt = hs_cnt + 1;
    do_accept(xv, cv);
    in_valid = 1'b0;
    scramble();
    get_result(r, lat);
    check(name, r, want);
    check({name, "_lat"}, W'(lat), W'(21));
    wait_hs(tgt, 1'b0);
  endtask

  initial begin
    logic [W-1:0] r;
    int           n;
    int           tgt;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    x           = '0;
    coef        = '0;
    out_ready   = 1'b1;
    s_in_valid  = 1'b0;
    s_x         = '0;
    s_coef      = '0;
    s_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("quartic_x2", 64'd2, pack5(1, 2, 3, 4, 5), 64'd57);
    check("quartic_x2_ovf_clear", W'(ovf), 0);
    directed("x_minus1", '1, pack5(1, 1, 1, 1, 1), 64'd1);
    directed("x_zero", 64'd0, pack5(9, 8, 7, 6, -64'sd7), 64'hFFFF_FFFF_FFFF_FFF9);

    // Backpressure: result held for 10 cycles with the consumer stalled.
    out_ready = 1'b0;
    tgt = hs_cnt + 1;
    do_accept(rnd64(), rnd_coef());
    in_valid = 1'b0;
    scramble();
    get_result(r, n);
    repeat (10) begin
      @(posedge clk);
      #1;
      check("bp_out_valid_held", W'(out_valid), 1);
      check("bp_res_stable", res, r);
      check("bp_in_ready_low", W'(in_ready), 0);
    end
    out_ready = 1'b1;
    wait_hs(tgt, 1'b0);

    // Back-to-back with in_valid held; inputs change right after each accept.
    tgt = hs_cnt + 3;
    do_accept(rnd64(), rnd_coef());
    gap_checks = 2;
    do_accept(rnd64(), rnd_coef());
    do_accept(rnd64(), rnd_coef());
    in_valid = 1'b0;
    scramble();
    wait_hs(tgt, 1'b0);
    check("b2b_gap_checks_done", W'(gap_checks), 0);

    // Reset in the middle of an evaluation.
    do_accept(rnd64(), rnd_coef());
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), 0);
    check("midrst_in_ready", W'(in_ready), 1);
    check("midrst_busy", W'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (LAT + 5) @(posedge clk);
    #1;
    directed("after_rst_x3", 64'd3, pack5(1, 1, 1, 1, 1), 64'd121);

`ifdef HORNER_OVF_EN
    tgt = hs_cnt + 1;
    do_accept(64'h1_0000_0000, pack5(1, 0, 0, 0, 0));
    in_valid = 1'b0;
    get_result(r, n);
    check("ovf_wrap_res", r, 0);
    check("ovf_wrap_flag", W'(ovf), 1);
    wait_hs(tgt, 1'b0);
`endif

    // Randomized operands, gaps and consumer backpressure.
    for (int i = 0; i < 25; i++) begin
      tgt = hs_cnt + 1;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      do_accept(rnd64(), rnd_coef());
      in_valid = 1'b0;
      scramble();
      wait_hs(tgt, 1'b1);
    end
    out_ready = 1'b1;

    // Degree-1, single-cycle-unit configuration.
    @(posedge clk);
    #1;
    s_in_valid = 1'b1;
    s_x        = 64'd5;
    s_coef     = {64'd2, 64'd1};
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_x        = 64'd77;
    n = 0;
    while (!s_out_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("small_res", s_res, 64'd11);
    check("small_lat", W'(n), 3);
    check("small_ovf", W'(s_ovf), 0);
    @(posedge clk);
    #1;
    check("small_idle_after_hs", W'(s_in_ready), 1);

    repeat (3) @(posedge clk);
    check("queue_drained", W'(exp_res.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
